// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_pkg
// Description : Shared types and constants for the instruction-fetch
//               controller: FSM state encoding, bus widths, default trap
//               vector and an alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_ctrl_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] TRAP_VEC_DEFAULT = 32'h0000_0100;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } fetch_state_e;

    // Instruction addresses must be word aligned.
    function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_if
// Description : Fetch-side bus bundle: instruction-memory request/response
//               channel plus the one-entry instruction handoff to decode.
//   master : fetch controller (drives requests and the decode handoff)
//   slave  : environment (memory + decode)
//   imem_req_valid/ready/addr  : request handshake, address
//   imem_rsp_valid/data        : one response per accepted request
//   if_valid/ready/instr/pc    : buffered instruction toward decode
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;

    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               if_valid;
    logic               if_ready;
    logic [INSTR_W-1:0] if_instr;
    logic [ADDR_W-1:0]  if_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output if_valid, if_instr, if_pc,
        input  if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  if_valid, if_instr, if_pc,
        output if_ready
    );

endinterface
`default_nettype wire

// File: rtl/fetch_ctrl_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buf
// Description : One-entry instruction buffer toward decode with a delivered
//               instruction counter.
//   clk, rst          : clock, asynchronous active-high reset
//   load, load_instr,
//   load_pc           : capture a new word (wins over a same-cycle consume)
//   flush             : discard the buffered word (redirect)
//   ready             : decode ready; consume = valid && ready
//   valid, instr, pc  : buffered instruction
//   count             : consumes so far, wraps modulo 2^CNT_W
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buf
    import fetch_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [ADDR_W-1:0]  load_pc,
    input  logic               flush,
    input  logic               ready,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc,
    output logic [CNT_W-1:0]   count
);

    logic consume;
    assign consume = valid && ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
            count <= '0;
        end else begin
            // A flush never coincides with a load; a consume in the flush
            // cycle has already happened at the decode side and still counts.
            if (flush) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= 1'b1;
                instr <= load_instr;
                pc    <= load_pc;
            end else if (consume) begin
                valid <= 1'b0;
            end
            if (consume) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Program-counter sequencing and instruction fetch. One
//               outstanding memory request and one buffered instruction;
//               branch/trap redirects squash in-flight fetches.
//   clk, rst            : clock, asynchronous active-high reset
//   boot_addr           : first fetch address (used in S_BOOT)
//   pc_out              : current PC from the external PC register
//   pc_load, pc_in      : PC register control (pc_load=0 -> PC += 4)
//   br_valid, br_target : branch redirect from execute
//   trap_valid          : trap redirect (to TRAP_VEC)
//   bus                 : imem request/response and decode handoff
//   misalign_err        : registered pulse for a misaligned branch target
//   fetch_count         : instructions delivered to decode
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] TRAP_VEC = TRAP_VEC_DEFAULT,
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] boot_addr,
    input  logic [ADDR_W-1:0] pc_out,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_in,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              trap_valid,
    fetch_ctrl_if.master      bus,
    output logic              misalign_err,
    output logic [CNT_W-1:0]  fetch_count
);

    fetch_state_e      state, state_nxt;
    logic              kill, kill_nxt;
    logic [ADDR_W-1:0] req_pc;

    logic              redirect;
    logic              br_misalign;
    logic [ADDR_W-1:0] target;
    logic              req_valid;
    logic              req_fire;
    logic              buf_free;
    logic              buf_load;

    logic               buf_valid;
    logic [INSTR_W-1:0] buf_instr;
    logic [ADDR_W-1:0]  buf_pc;

    // Redirect inputs are meaningless during the boot cycle.
    always_comb begin
        redirect    = (state != S_BOOT) && (trap_valid || br_valid);
        br_misalign = (state != S_BOOT) && br_valid && !trap_valid
                      && is_misaligned(br_target);
        target      = (trap_valid || br_misalign) ? TRAP_VEC : br_target;
    end

    assign buf_free = !buf_valid || bus.if_ready;
    assign req_fire = req_valid && bus.imem_req_ready;

    always_comb begin
        state_nxt = state;
        kill_nxt  = kill;
        pc_load   = 1'b1;
        pc_in     = pc_out;
        req_valid = 1'b0;
        buf_load  = 1'b0;
        case (state)
            S_BOOT: begin
                pc_in     = boot_addr;
                state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (redirect) begin
                    pc_in = target;
                end else begin
                    req_valid = buf_free;
                    if (buf_free && bus.imem_req_ready) begin
                        pc_load   = 1'b0;
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_in = target;
                    // The outstanding response must still be absorbed; if it
                    // is not here yet, remember to drop it when it arrives.
                    if (bus.imem_rsp_valid) begin
                        kill_nxt  = 1'b0;
                        state_nxt = S_ISSUE;
                    end else begin
                        kill_nxt = 1'b1;
                    end
                end else if (bus.imem_rsp_valid) begin
                    buf_load  = !kill;
                    kill_nxt  = 1'b0;
                    state_nxt = S_ISSUE;
                end
            end
            default: begin
                state_nxt = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_BOOT;
            kill         <= 1'b0;
            req_pc       <= '0;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            kill         <= kill_nxt;
            misalign_err <= br_misalign;
            if (req_fire) begin
                req_pc <= pc_out;
            end
        end
    end

    fetch_buf #(
        .CNT_W (CNT_W)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .load_instr (bus.imem_rsp_data),
        .load_pc    (req_pc),
        .flush      (redirect),
        .ready      (bus.if_ready),
        .valid      (buf_valid),
        .instr      (buf_instr),
        .pc         (buf_pc),
        .count      (fetch_count)
    );

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_out;
    assign bus.if_valid       = buf_valid;
    assign bus.if_instr       = buf_instr;
    assign bus.if_pc          = buf_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Self-checking bench for fetch_ctrl. Provides the PC register
//               and a one-outstanding instruction memory, directed scenarios
//               and a randomized run against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    localparam logic [31:0] TV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] boot_addr = 32'h1000;
    logic [31:0] pc_out = '0;
    logic        pc_load;
    logic [31:0] pc_in;
    logic        br_valid = 1'b0;
    logic [31:0] br_target = '0;
    logic        trap_valid = 1'b0;
    logic        misalign_err;
    logic [31:0] fetch_count;

    fetch_ctrl_if bus();

    fetch_ctrl #(.TRAP_VEC(TV), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .boot_addr    (boot_addr),
        .pc_out       (pc_out),
        .pc_load      (pc_load),
        .pc_in        (pc_in),
        .br_valid     (br_valid),
        .br_target    (br_target),
        .trap_valid   (trap_valid),
        .bus          (bus),
        .misalign_err (misalign_err),
        .fetch_count  (fetch_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // environment state
    logic        rst_drv = 1'b1;
    logic        mem_rdy_rand = 1'b0;
    int          lat_min = 1, lat_max = 1;
    logic        mem_busy = 1'b0;
    logic [31:0] mem_addr = '0;
    int          mem_wait = 0;
    logic [31:0] pc_next = '0;

    // per-cycle observations
    logic        o_req, o_acc, o_rsp, o_pc_load, o_ifv, o_mis;
    logic [31:0] o_addr, o_pc_in, o_pc_out, o_ifpc, o_instr, o_cnt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    // One clock: drive at negedge, sample 1 time unit later, then let the
    // posedge happen and advance the PC register and memory models.
    task automatic tick(input logic br, input logic tr, input logic [31:0] tgt,
                        input logic rdy);
        @(negedge clk);
        rst                = rst_drv;
        pc_out             = pc_next;
        br_valid           = br;
        trap_valid         = tr;
        br_target          = tgt;
        bus.if_ready       = rdy;
        bus.imem_req_ready = mem_rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.imem_rsp_valid = mem_busy && (mem_wait == 0);
        bus.imem_rsp_data  = bus.imem_rsp_valid ? mem_word(mem_addr) : 32'hDEAD_BEEF;
        #1;
        o_req     = bus.imem_req_valid;
        o_addr    = bus.imem_req_addr;
        o_acc     = bus.imem_req_valid && bus.imem_req_ready;
        o_rsp     = bus.imem_rsp_valid;
        o_pc_load = pc_load;
        o_pc_in   = pc_in;
        o_pc_out  = pc_out;
        o_ifv     = bus.if_valid;
        o_ifpc    = bus.if_pc;
        o_instr   = bus.if_instr;
        o_mis     = misalign_err;
        o_cnt     = fetch_count;
        @(posedge clk);
        pc_next = o_pc_load ? o_pc_in : o_pc_out + 32'd4;
        if (o_rsp) mem_busy = 1'b0;
        else if (mem_busy && mem_wait > 0) mem_wait = mem_wait - 1;
        if (o_acc) begin
            mem_busy = 1'b1;
            mem_addr = o_addr;
            mem_wait = int'($urandom_range(lat_max, lat_min)) - 1;
        end
    endtask

    task automatic do_reset(input logic [31:0] ba, input int lmin, input int lmax);
        boot_addr = ba;
        lat_min   = lmin;
        lat_max   = lmax;
        rst_drv   = 1'b1;
        repeat (2) tick(1'b0, 1'b0, 32'h0, 1'b0);
        rst_drv   = 1'b0;
    endtask

    task automatic test_reset();
        mem_rdy_rand = 1'b0;
        boot_addr = 32'h1000;
        rst_drv = 1'b1;
        repeat (3) tick(1'b1, 1'b1, 32'h5000, 1'b1);
        n_cmp++; if (o_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", o_req); end
        n_cmp++; if (o_pc_load !== 1'b1 || o_pc_in !== 32'h1000) begin n_err++; $display("FAIL reset_pc: got load=%b in=%h want 1/00001000", o_pc_load, o_pc_in); end
        n_cmp++; if (o_ifv !== 1'b0 || o_mis !== 1'b0 || o_cnt !== 32'd0) begin n_err++; $display("FAIL reset_regs: got v=%b mis=%b cnt=%0d want 0/0/0", o_ifv, o_mis, o_cnt); end
        rst_drv = 1'b0;
        // boot cycle: a misaligned branch here must be ignored
        tick(1'b1, 1'b0, 32'h5002, 1'b1);
        n_cmp++; if (o_req !== 1'b0 || o_pc_in !== 32'h1000 || o_pc_load !== 1'b1) begin n_err++; $display("FAIL boot_cycle: got req=%b load=%b in=%h want 0/1/00001000", o_req, o_pc_load, o_pc_in); end
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        n_cmp++; if (o_req !== 1'b1 || o_addr !== 32'h1000 || o_mis !== 1'b0) begin n_err++; $display("FAIL boot_first_req: got req=%b addr=%h mis=%b want 1/00001000/0", o_req, o_addr, o_mis); end
    endtask

    task automatic test_sequential();
        logic [31:0] reqs[$];
        logic [31:0] pcs[$];
        int guard = 0;
        logic [31:0] want;
        do_reset(32'h1000, 1, 1);
        while (pcs.size() < 3 && guard < 40) begin
            tick(1'b0, 1'b0, 32'h0, 1'b1);
            guard++;
            if (o_acc) reqs.push_back(o_addr);
            if (o_ifv) begin
                pcs.push_back(o_ifpc);
                n_cmp++; if (o_instr !== mem_word(o_ifpc)) begin n_err++; $display("FAIL seq_instr: got %h want %h", o_instr, mem_word(o_ifpc)); end
            end
        end
        n_cmp++; if (pcs.size() != 3) begin n_err++; $display("FAIL seq_timeout: got %0d deliveries want 3", pcs.size()); end
        for (int i = 0; i < 3; i++) begin
            want = 32'h1000 + 32'(4 * i);
            n_cmp++; if (reqs.size() <= i || reqs[i] !== want) begin n_err++; $display("FAIL seq_req%0d: got %h want %h", i, (reqs.size() > i) ? reqs[i] : 32'hx, want); end
            n_cmp++; if (pcs.size() <= i || pcs[i] !== want) begin n_err++; $display("FAIL seq_ifpc%0d: got %h want %h", i, (pcs.size() > i) ? pcs[i] : 32'hx, want); end
        end
        n_cmp++; if (guard > 8) begin n_err++; $display("FAIL seq_rate: got %0d cycles want <=8", guard); end
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        n_cmp++; if (o_cnt !== 32'd3) begin n_err++; $display("FAIL seq_count: got %0d want 3", o_cnt); end
    endtask

    task automatic test_backpressure();
        int acc_n = 0;
        logic [31:0] p1;
        do_reset(32'h1000, 1, 1);
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (6) begin
            tick(1'b0, 1'b0, 32'h0, 1'b0);
            if (o_acc) acc_n++;
        end
        n_cmp++; if (acc_n != 1) begin n_err++; $display("FAIL bp_req_count: got %0d want 1", acc_n); end
        n_cmp++; if (o_ifv !== 1'b1 || o_ifpc !== 32'h1000) begin n_err++; $display("FAIL bp_buffered: got v=%b pc=%h want 1/00001000", o_ifv, o_ifpc); end
        p1 = o_pc_out;
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        n_cmp++; if (o_req !== 1'b0 || o_pc_out !== p1 || o_pc_out !== 32'h1004) begin n_err++; $display("FAIL bp_hold: got req=%b pc=%h want 0/00001004", o_req, o_pc_out); end
        // releasing decode frees the buffer in the same cycle
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        n_cmp++; if (o_req !== 1'b1 || o_addr !== 32'h1004) begin n_err++; $display("FAIL bp_resume: got req=%b addr=%h want 1/00001004", o_req, o_addr); end
    endtask

    task automatic test_branch_wait();
        int guard = 0;
        logic saw_v = 1'b0, saw_rsp = 1'b0, got_req = 1'b0;
        do_reset(32'h1000, 4, 4);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        while (!o_acc && guard < 10) begin tick(1'b0, 1'b0, 32'h0, 1'b1); guard++; end
        tick(1'b1, 1'b0, 32'h2000, 1'b1);
        n_cmp++; if (o_pc_load !== 1'b1 || o_pc_in !== 32'h2000 || o_req !== 1'b0) begin n_err++; $display("FAIL br_redirect: got load=%b in=%h req=%b want 1/00002000/0", o_pc_load, o_pc_in, o_req); end
        guard = 0;
        while (!got_req && guard < 15) begin
            tick(1'b0, 1'b0, 32'h0, 1'b1);
            guard++;
            if (o_ifv) saw_v = 1'b1;
            if (o_rsp) saw_rsp = 1'b1;
            if (o_req) got_req = 1'b1;
        end
        n_cmp++; if (saw_v !== 1'b0) begin n_err++; $display("FAIL br_dropped: got if_valid=1 want 0"); end
        n_cmp++; if (!got_req || !saw_rsp || o_addr !== 32'h2000 || guard != 4) begin n_err++; $display("FAIL br_next_req: got req=%b rsp=%b addr=%h cyc=%0d want 1/1/00002000/4", got_req, saw_rsp, o_addr, guard); end
        guard = 0;
        while (!o_ifv && guard < 15) begin tick(1'b0, 1'b0, 32'h0, 1'b1); guard++; end
        n_cmp++; if (o_ifv !== 1'b1 || o_ifpc !== 32'h2000 || o_instr !== mem_word(32'h2000)) begin n_err++; $display("FAIL br_deliver: got v=%b pc=%h instr=%h want 1/00002000/%h", o_ifv, o_ifpc, o_instr, mem_word(32'h2000)); end
    endtask

    task automatic test_trap_priority();
        int guard = 0;
        do_reset(32'h1000, 1, 1);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        // S_WAIT with the response arriving in the same cycle
        tick(1'b1, 1'b1, 32'h3000, 1'b1);
        n_cmp++; if (o_pc_load !== 1'b1 || o_pc_in !== TV) begin n_err++; $display("FAIL trap_pc: got load=%b in=%h want 1/%h", o_pc_load, o_pc_in, TV); end
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        n_cmp++; if (o_req !== 1'b1 || o_addr !== TV || o_mis !== 1'b0) begin n_err++; $display("FAIL trap_next_req: got req=%b addr=%h mis=%b want 1/%h/0", o_req, o_addr, o_mis, TV); end
        while (!o_ifv && guard < 15) begin tick(1'b0, 1'b0, 32'h0, 1'b1); guard++; end
        n_cmp++; if (o_ifv !== 1'b1 || o_ifpc !== TV) begin n_err++; $display("FAIL trap_deliver: got v=%b pc=%h want 1/%h", o_ifv, o_ifpc, TV); end
    endtask

    task automatic test_misalign();
        do_reset(32'h1000, 1, 1);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        // S_ISSUE with a valid word being consumed
        tick(1'b1, 1'b0, 32'h2002, 1'b1);
        n_cmp++; if (o_pc_in !== TV || o_req !== 1'b0 || o_mis !== 1'b0 || o_ifv !== 1'b1) begin n_err++; $display("FAIL mis_redirect: got in=%h req=%b mis=%b v=%b want %h/0/0/1", o_pc_in, o_req, o_mis, o_ifv, TV); end
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        n_cmp++; if (o_mis !== 1'b1) begin n_err++; $display("FAIL mis_pulse: got %b want 1", o_mis); end
        n_cmp++; if (o_req !== 1'b1 || o_addr !== TV || o_ifv !== 1'b0 || o_cnt !== 32'd1) begin n_err++; $display("FAIL mis_next_req: got req=%b addr=%h v=%b cnt=%0d want 1/%h/0/1", o_req, o_addr, o_ifv, o_cnt, TV); end
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        n_cmp++; if (o_mis !== 1'b0) begin n_err++; $display("FAIL mis_once: got %b want 0", o_mis); end
    endtask

    task automatic test_reset_midflight();
        int guard = 0;
        do_reset(32'h1000, 2, 2);
        repeat (7) tick(1'b0, 1'b0, 32'h0, 1'b1);
        while (!o_acc && guard < 10) begin tick(1'b0, 1'b0, 32'h0, 1'b1); guard++; end
        rst_drv = 1'b1;
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        rst_drv = 1'b0;
        boot_addr = 32'h4000;
        // boot cycle: the late response shows up now
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        n_cmp++; if (o_ifv !== 1'b0 || o_req !== 1'b0 || o_cnt !== 32'd0 || o_pc_in !== 32'h4000) begin n_err++; $display("FAIL rst_boot: got v=%b req=%b cnt=%0d in=%h rsp=%b want 0/0/0/00004000", o_ifv, o_req, o_cnt, o_pc_in, o_rsp); end
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        n_cmp++; if (o_req !== 1'b1 || o_addr !== 32'h4000 || o_ifv !== 1'b0) begin n_err++; $display("FAIL rst_first_req: got req=%b addr=%h v=%b want 1/00004000/0", o_req, o_addr, o_ifv); end
        guard = 0;
        while (!o_ifv && guard < 10) begin tick(1'b0, 1'b0, 32'h0, 1'b1); guard++; end
        n_cmp++; if (o_ifpc !== 32'h4000 || o_instr !== mem_word(32'h4000)) begin n_err++; $display("FAIL rst_deliver: got pc=%h instr=%h want 00004000/%h", o_ifpc, o_instr, mem_word(32'h4000)); end
    endtask

    // Transaction-level model: expected fetch address, one outstanding
    // request (possibly marked dropped), one delivered-word slot, counter.
    task automatic test_random();
        logic        boot = 1'b1, out = 1'b0, drop = 1'b0, bufv = 1'b0, prev_mis = 1'b0;
        logic [31:0] exp_addr, out_pc = '0, buf_pc = '0, cnt = '0, ba, tgt, exp_tgt;
        logic [31:0] exp_pc_in;
        logic        br, tr, rdy, redir, req_exp, exp_load;
        mem_rdy_rand = 1'b1;
        ba = $urandom() & 32'h000F_FFFC;
        do_reset(ba, 1, 3);
        exp_addr = ba;
        for (int c = 0; c < 1500; c++) begin
            br  = !boot && ($urandom_range(0, 9) == 0);
            tr  = !boot && ($urandom_range(0, 24) == 0);
            tgt = $urandom() & 32'h000F_FFFC;
            if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            rdy = ($urandom_range(0, 3) != 0);
            tick(br, tr, tgt, rdy);
            redir   = br || tr;
            exp_tgt = (tr || tgt[1:0] != 2'b00) ? TV : tgt;
            req_exp = !boot && !redir && !out && (!bufv || rdy);
            n_cmp++; if (o_req !== req_exp) begin n_err++; $display("FAIL rnd_req c%0d: got %b want %b", c, o_req, req_exp); end
            if (req_exp) begin
                n_cmp++; if (o_addr !== exp_addr) begin n_err++; $display("FAIL rnd_addr c%0d: got %h want %h", c, o_addr, exp_addr); end
            end
            if (boot)             begin exp_load = 1'b1; exp_pc_in = ba; end
            else if (redir)       begin exp_load = 1'b1; exp_pc_in = exp_tgt; end
            else if (o_acc)       begin exp_load = 1'b0; exp_pc_in = o_pc_in; end
            else                  begin exp_load = 1'b1; exp_pc_in = o_pc_out; end
            n_cmp++; if (o_pc_load !== exp_load || o_pc_in !== exp_pc_in) begin n_err++; $display("FAIL rnd_pc c%0d: got load=%b in=%h want %b/%h", c, o_pc_load, o_pc_in, exp_load, exp_pc_in); end
            n_cmp++; if (o_ifv !== bufv || (bufv && (o_ifpc !== buf_pc || o_instr !== mem_word(buf_pc)))) begin n_err++; $display("FAIL rnd_if c%0d: got v=%b pc=%h instr=%h want %b/%h", c, o_ifv, o_ifpc, o_instr, bufv, buf_pc); end
            n_cmp++; if (o_cnt !== cnt || o_mis !== prev_mis) begin n_err++; $display("FAIL rnd_cnt_mis c%0d: got cnt=%0d mis=%b want %0d/%b", c, o_cnt, o_mis, cnt, prev_mis); end
            if (bufv && rdy) begin bufv = 1'b0; cnt = cnt + 32'd1; end
            if (o_rsp && out) begin
                if (!drop && !redir) begin bufv = 1'b1; buf_pc = out_pc; end
                out = 1'b0;
                drop = 1'b0;
            end
            if (o_acc && req_exp) begin
                out = 1'b1; drop = 1'b0; out_pc = exp_addr;
                exp_addr = exp_addr + 32'd4;
            end
            if (redir) begin
                bufv = 1'b0;
                if (out) drop = 1'b1;
                exp_addr = exp_tgt;
            end
            prev_mis = br && !tr && (tgt[1:0] != 2'b00);
            boot = 1'b0;
        end
        mem_rdy_rand = 1'b0;
    endtask

    initial begin
        bus.if_ready       = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_branch_wait();
        test_trap_priority();
        test_misalign();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
